nes_pad_poller: RTL and testbench
=================================

# nes_pad_poller

Parametrised serial game-pad poller for NES (8-bit) and SNES (16-bit) controllers, for one or more pads sharing a latch and clock line. It generates the latch and controller clock from a programmable divider of `clk`, with no gating of `clk`. It shifts in every pad's serial line and presents debounced-by-frame button words plus per-button pressed/released event masks. It sits between the top-level pad pins and game logic, and supports both on-demand and periodic auto-polling.

## Interface
- `NUM_CONTROLLERS`, 4: number of pads (serial inputs).
- `BITS`, 8: bits per pad; 8 = NES, 16 = SNES; legal range 1..32.
- `CLK_DIV`, 50: `clk` cycles per controller-clock half-period; ≥1. Choose so that 2*`CLK_DIV` periods ≥ 2 µs.
- `AUTO_POLL_PERIOD`, 0: 0 = auto-poll off; otherwise idle cycles between fetches.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_fetch_i` in 1: request one fetch; sampled only in IDLE.
- `busy_o` out 1: high while a fetch is in progress (any state but IDLE).
- `valid_o` out 1: one-cycle pulse; new data and event masks are valid this cycle.
- `controller_clk_o` out 1: pad clock, registered, idles high.
- `controller_latch_o` out 1: pad latch, registered, active-high.
- `controller_serial_LIST_ni` in `NUM_CONTROLLERS`: pad serial data, active-low (0 = pressed).
- `data_LIST_o` out `BITS*NUM_CONTROLLERS`: pad k at `[BITS*k +: BITS]`, 1 = pressed; holds its value between fetches.
- `pressed_LIST_o` out `BITS*NUM_CONTROLLERS`: new & ~old per bit; same layout; valid only with `valid_o`.
- `released_LIST_o` out `BITS*NUM_CONTROLLERS`: old & ~new per bit; same layout; valid only with `valid_o`.

## Operation
- States: IDLE, LATCH, LOW, HIGH, DONE.
- **IDLE.** Latch is 0 and clock is 1. A fetch trigger moves to LATCH, and the half-period divider and the bit counter clear.
  - Trigger = `start_fetch_i`, or (`AUTO_POLL_PERIOD`>0 and poll counter == `AUTO_POLL_PERIOD`-1).
  - The poll counter increments each IDLE cycle and clears on fetch start.
  - Simultaneous manual and auto triggers start exactly one fetch.
- **LATCH.** Latch is 1 and clock is 1 for 2*`CLK_DIV` cycles, then the block goes to LOW.
- **LOW.** Clock is 0 for `CLK_DIV` cycles. On the last LOW cycle, every pad samples the inverted serial bit and shifts it into its own shift register from the LSB.
  - The first sampled bit ends at bit `BITS`-1.
  - The last sampled bit ends at bit 0.
- **HIGH.** Clock is 1 for `CLK_DIV` cycles; the rising edge advances the pad to its next bit.
  - After the `BITS`-th HIGH the block goes to DONE; otherwise it goes back to LOW.
- **DONE.** One cycle, then IDLE.
  - `data_LIST_o` and both event masks are registered from the shift registers at the DONE entry edge, so they are visible during the DONE cycle.
  - `valid_o` is 1 during the DONE cycle.
- Event masks are 0 in every cycle where `valid_o`=0.
- `start_fetch_i` is ignored in every state other than IDLE and is not queued.
- Divider width is `$clog2(CLK_DIV+1)`. Bit counter width is `$clog2(BITS+1)`. No counter wraps beyond its terminal count.
- **Reset values:**
  - `controller_latch_o`=0, `controller_clk_o`=1.
  - `busy_o`=0, `valid_o`=0.
  - `data_LIST_o`=0, `pressed_LIST_o`=0, `released_LIST_o`=0.
  - State IDLE; poll counter, divider and shift registers all 0.
- Reset mid-fetch aborts immediately: no `valid_o`, and data returns to 0.

## Timing
- Cycle 0 is the IDLE cycle in which the trigger is sampled.
- Latch is high in cycles 1..2*`CLK_DIV`.
- Bit i (0-based) has:
  - LOW in cycles 2*`CLK_DIV`*(i+1)+1 .. 2*`CLK_DIV`*(i+1)+`CLK_DIV`;
  - sampling in the last of those cycles;
  - HIGH in the next `CLK_DIV` cycles.
- `valid_o` is high in cycle L = 2*`CLK_DIV`*(`BITS`+1)+1, and `busy_o` is high for cycles 1..L.
- The next manual trigger can be accepted at cycle L+1.
- With auto-poll, consecutive fetch starts are L+`AUTO_POLL_PERIOD` cycles apart. After reset, the first auto fetch starts in cycle `AUTO_POLL_PERIOD`-1.
- `controller_clk_o` and `controller_latch_o` change only on `clk` rising edges and are glitch-free.

## Test plan
- **Reset.**
  - Stimulus: assert `rst` 3 cycles, with `NUM_CONTROLLERS`=2, `BITS`=8, `CLK_DIV`=2.
  - Response: latch 0, clock 1, busy 0, valid 0, all data and masks 0.
- **NES fetch.**
  - Stimulus: pad model on pad 0 returns the 0xA3 pattern (active-low, first bit = bit 7); pad 1 returns all released; pulse start.
  - Response: `valid_o` exactly at cycle 37; `data_LIST_o`=0x00A3; pressed=0x00A3; released=0; exactly 8 clock low pulses.
- **Edge events.**
  - Stimulus: second fetch where pad 0 returns 0xC1.
  - Response: data=0x00C1, pressed=0x0040, released=0x0022; masks 0 the cycle after.
- **SNES.**
  - Stimulus: `BITS`=16, `CLK_DIV`=2, pad 0 returns 0x8001.
  - Response: valid at cycle 69, data[15:0]=0x8001, 16 clock pulses.
- **Busy / auto.**
  - Stimulus: start re-pulsed at cycle 10 of a fetch.
  - Response: ignored, only one valid.
  - Stimulus: `AUTO_POLL_PERIOD`=10, no manual start.
  - Response: fetch starts at cycles 9, 56, 103 (L=37).
- **Reset mid-fetch.**
  - Stimulus: `rst` at cycle 20.
  - Response: next cycle latch 0, clock 1, busy 0, data 0, no valid.
  - Stimulus: a fresh start afterwards.
  - Response: completes normally.

Source files
------------

// File: rtl/nes_pad_poller.sv
// Serial game-pad poller for NES/SNES pads sharing one latch and clock line.
// Generates latch/clock from a clk divider and presents per-frame button words with edge masks.
module nes_pad_poller #(
  parameter int unsigned NUM_CONTROLLERS  = 4,
  parameter int unsigned BITS             = 8,
  parameter int unsigned CLK_DIV          = 50,
  parameter int unsigned AUTO_POLL_PERIOD = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_fetch_i,
  output logic                              busy_o,
  output logic                              valid_o,
  output logic                              controller_clk_o,
  output logic                              controller_latch_o,
  input  logic [NUM_CONTROLLERS-1:0]        controller_serial_LIST_ni,
  output logic [BITS*NUM_CONTROLLERS-1:0]   data_LIST_o,
  output logic [BITS*NUM_CONTROLLERS-1:0]   pressed_LIST_o,
  output logic [BITS*NUM_CONTROLLERS-1:0]   released_LIST_o
);

  localparam int unsigned DW        = $clog2(CLK_DIV + 1);
  localparam int unsigned BW        = $clog2(BITS + 1);
  localparam int unsigned PW        = (AUTO_POLL_PERIOD > 1) ? $clog2(AUTO_POLL_PERIOD) : 1;
  localparam int unsigned POLL_LAST = (AUTO_POLL_PERIOD > 0) ? AUTO_POLL_PERIOD - 1 : 0;
  localparam bit          AUTO_EN   = (AUTO_POLL_PERIOD > 0);
  localparam int unsigned W         = BITS * NUM_CONTROLLERS;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div, div_next;
  logic [BW-1:0]   bit_cnt, bit_next;
  logic [PW-1:0]   poll, poll_next;
  logic [W-1:0]    shift;
  logic            sample;
  logic            div_last;
  logic            trigger;

  assign div_last = (div == DW'(CLK_DIV - 1));
  assign trigger  = start_fetch_i || (AUTO_EN && (poll == PW'(POLL_LAST)));

  always_comb begin
    state_next = state;
    div_next   = div;
    bit_next   = bit_cnt;
    poll_next  = poll;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = LATCH;
          div_next   = '0;
          bit_next   = '0;
          poll_next  = '0;
        end else if (AUTO_EN) begin
          poll_next = poll + PW'(1);
        end
      end
      // Latch spans two half-periods; bit_cnt doubles as the half flag here
      // so the divider stays only wide enough for CLK_DIV.
      LATCH: begin
        if (div_last) begin
          div_next = '0;
          if (bit_cnt == '0) begin
            bit_next = BW'(1);
          end else begin
            bit_next   = '0;
            state_next = LOW;
          end
        end else begin
          div_next = div + DW'(1);
        end
      end
      LOW: begin
        if (div_last) begin
          div_next   = '0;
          sample     = 1'b1;
          state_next = HIGH;
        end else begin
          div_next = div + DW'(1);
        end
      end
      HIGH: begin
        if (div_last) begin
          div_next = '0;
          if (bit_cnt == BW'(BITS - 1)) begin
            state_next = DONE;
          end else begin
            bit_next   = bit_cnt + BW'(1);
            state_next = LOW;
          end
        end else begin
          div_next = div + DW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      div                <= '0;
      bit_cnt            <= '0;
      poll               <= '0;
      shift              <= '0;
      controller_latch_o <= 1'b0;
      controller_clk_o   <= 1'b1;
      busy_o             <= 1'b0;
      valid_o            <= 1'b0;
      data_LIST_o        <= '0;
      pressed_LIST_o     <= '0;
      released_LIST_o    <= '0;
    end else begin
      state              <= state_next;
      div                <= div_next;
      bit_cnt            <= bit_next;
      poll               <= poll_next;
      // Pin outputs decode the next state so they change with it, glitch-free.
      controller_latch_o <= (state_next == LATCH);
      controller_clk_o   <= (state_next != LOW);
      busy_o             <= (state_next != IDLE);
      valid_o            <= (state_next == DONE);
      if (sample) begin
        for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
          shift[BITS*k +: BITS] <= BITS'({shift[BITS*k +: BITS], ~controller_serial_LIST_ni[k]});
        end
      end
      if (state_next == DONE) begin
        data_LIST_o     <= shift;
        pressed_LIST_o  <= shift & ~data_LIST_o;
        released_LIST_o <= data_LIST_o & ~shift;
      end else begin
        pressed_LIST_o  <= '0;
        released_LIST_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: NES, SNES and auto-poll instances with pad models,
// a queue-based scoreboard per fetching instance and a per-cycle pin-timing model.
module tb_nes_pad_poller;

  localparam int unsigned NC  = 2;
  localparam int unsigned CD  = 2;
  localparam int unsigned BA  = 8;
  localparam int unsigned BB  = 16;
  localparam int unsigned APP = 10;
  localparam int unsigned LA  = 2*CD*(BA+1) + 1;
  localparam int unsigned LB  = 2*CD*(BB+1) + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic [31:0] pressed;
    logic [31:0] released;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: NES, manual
  logic start_a = 1'b0, busy_a, valid_a, pclk_a, latch_a;
  logic [NC-1:0] ser_a = '1;
  logic [BA*NC-1:0] data_a, pr_a, rl_a;
  // instance B: SNES, manual
  logic start_b = 1'b0, busy_b, valid_b, pclk_b, latch_b;
  logic [NC-1:0] ser_b = '1;
  logic [BB*NC-1:0] data_b, pr_b, rl_b;
  // instance C: NES, auto-poll only
  logic busy_c, valid_c, pclk_c, latch_c;
  logic [BA*NC-1:0] data_c, pr_c, rl_c;

  nes_pad_poller #(.NUM_CONTROLLERS(NC), .BITS(BA), .CLK_DIV(CD), .AUTO_POLL_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .start_fetch_i(start_a), .busy_o(busy_a), .valid_o(valid_a),
    .controller_clk_o(pclk_a), .controller_latch_o(latch_a), .controller_serial_LIST_ni(ser_a),
    .data_LIST_o(data_a), .pressed_LIST_o(pr_a), .released_LIST_o(rl_a));

  nes_pad_poller #(.NUM_CONTROLLERS(NC), .BITS(BB), .CLK_DIV(CD), .AUTO_POLL_PERIOD(0)) dut_b (
    .clk(clk), .rst(rst2), .start_fetch_i(start_b), .busy_o(busy_b), .valid_o(valid_b),
    .controller_clk_o(pclk_b), .controller_latch_o(latch_b), .controller_serial_LIST_ni(ser_b),
    .data_LIST_o(data_b), .pressed_LIST_o(pr_b), .released_LIST_o(rl_b));

  nes_pad_poller #(.NUM_CONTROLLERS(NC), .BITS(BA), .CLK_DIV(CD), .AUTO_POLL_PERIOD(APP)) dut_c (
    .clk(clk), .rst(rst2), .start_fetch_i(1'b0), .busy_o(busy_c), .valid_o(valid_c),
    .controller_clk_o(pclk_c), .controller_latch_o(latch_c), .controller_serial_LIST_ni(2'b11),
    .data_LIST_o(data_c), .pressed_LIST_o(pr_c), .released_LIST_o(rl_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad line level for read number idx: button word MSB first, 0 = pressed.
  function automatic logic pad_bit(input logic [31:0] w, input int unsigned nbits, input int unsigned idx);
    logic [31:0] s;
    if (idx >= nbits) return 1'b0;
    s = w >> (nbits - 1 - idx);
    return ~s[0];
  endfunction

  // Pad models: latch reloads, each controller-clock rising edge advances.
  logic [BA-1:0] word_a [NC];
  logic [BB-1:0] word_b [NC];
  int unsigned idx_a = 0, idx_b = 0;
  logic pprev_a = 1'b1, pprev_b = 1'b1;

  always @(negedge clk) begin
    if (latch_a) idx_a = 0;
    else if (pclk_a && !pprev_a) idx_a++;
    pprev_a = pclk_a;
    ser_a = {pad_bit(32'(word_a[1]), BA, idx_a), pad_bit(32'(word_a[0]), BA, idx_a)};
    if (latch_b) idx_b = 0;
    else if (pclk_b && !pprev_b) idx_b++;
    pprev_b = pclk_b;
    ser_b = {pad_bit(32'(word_b[1]), BB, idx_b), pad_bit(32'(word_b[0]), BB, idx_b)};
  end

  // Reference model state
  exp_t qa[$];
  exp_t qb[$];
  logic [BA*NC-1:0] prev_a = '0;
  logic [BB*NC-1:0] prev_b = '0;
  int unsigned start_a_cyc = 0;
  bit act_a = 1'b0;

  // Monitor A: pin timing per cycle, scoreboard on valid
  int unsigned pulses_a = 0;
  logic mprev_a = 1'b1;
  always @(posedge clk) begin
    int unsigned t;
    bit in_f;
    exp_t e;
    #1;
    t = cyc - start_a_cyc;
    in_f = act_a && (cyc > start_a_cyc) && (t <= LA);
    check("busy_a", busy_a, in_f);
    check("latch_a", latch_a, in_f && (t <= 2*CD));
    check("pclk_a", pclk_a, !(in_f && (t > 2*CD) && (t < LA) && (((t - 2*CD - 1) % (2*CD)) < CD)));
    if (rst) pulses_a = 0;
    else if (mprev_a && !pclk_a) pulses_a++;
    mprev_a = pclk_a;
    if (qa.size() > 0 && cyc > qa[0].cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_a_missing: none by cycle %0d, required at cycle %0d", cyc, qa[0].cyc);
      qa.delete(0);
    end
    if (valid_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL valid_a_unexpected: valid at cycle %0d, required none", cyc);
      end else begin
        e = qa.pop_front();
        check("valid_a_cycle", cyc, e.cyc);
        check("data_a", data_a, e.data);
        check("pressed_a", pr_a, e.pressed);
        check("released_a", rl_a, e.released);
        check("pulses_a", pulses_a, BA);
      end
      pulses_a = 0;
    end else begin
      check("pressed_a_idle", pr_a, 0);
      check("released_a_idle", rl_a, 0);
    end
  end

  // Monitor B: scoreboard on valid
  int unsigned pulses_b = 0;
  logic mprev_b = 1'b1;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst2) pulses_b = 0;
    else if (mprev_b && !pclk_b) pulses_b++;
    mprev_b = pclk_b;
    if (qb.size() > 0 && cyc > qb[0].cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_b_missing: none by cycle %0d, required at cycle %0d", cyc, qb[0].cyc);
      qb.delete(0);
    end
    if (valid_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL valid_b_unexpected: valid at cycle %0d, required none", cyc);
      end else begin
        e = qb.pop_front();
        check("valid_b_cycle", cyc, e.cyc);
        check("data_b", data_b, e.data);
        check("pressed_b", pr_b, e.pressed);
        check("released_b", rl_b, e.released);
        check("pulses_b", pulses_b, BB);
      end
      pulses_b = 0;
    end else begin
      check("pressed_b_idle", pr_b, 0);
    end
  end

  // Monitor C: auto-poll fetch start cycles relative to reset release
  int unsigned c0 = 0, nstart_c = 0;
  logic bprev_c = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst2) begin
      c0 = cyc;
      nstart_c = 0;
    end else if (busy_c && !bprev_c) begin
      if (nstart_c < 3) check("auto_start_c", cyc - 1 - c0, (APP - 1) + nstart_c*(LA + APP));
      nstart_c++;
    end
    bprev_c = busy_c;
  end

  task automatic wait_idle_a();
    int unsigned n = 0;
    while (busy_a && n < 200) begin @(negedge clk); n++; end
    if (busy_a) begin n_cmp++; n_bad++; $display("FAIL idle_a_timeout: busy still 1 at cycle %0d", cyc); end
  endtask

  task automatic wait_done_a();
    int unsigned n = 0;
    while (qa.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (qa.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_a_timeout: %0d results pending, required 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic wait_done_b();
    int unsigned n = 0;
    while (qb.size() > 0 && n < 300) begin @(negedge clk); n++; end
    if (qb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_b_timeout: %0d results pending, required 0", qb.size());
      qb.delete();
    end
  endtask

  task automatic fetch_a(input logic [BA-1:0] w0, input logic [BA-1:0] w1);
    exp_t e;
    logic [BA*NC-1:0] nw;
    wait_idle_a();
    word_a[0] = w0;
    word_a[1] = w1;
    nw = {w1, w0};
    e.cyc = cyc + LA;
    e.data = 32'(nw);
    e.pressed = 32'(nw & ~prev_a);
    e.released = 32'(prev_a & ~nw);
    prev_a = nw;
    qa.push_back(e);
    start_a_cyc = cyc;
    act_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic fetch_b(input logic [BB-1:0] w0, input logic [BB-1:0] w1);
    exp_t e;
    logic [BB*NC-1:0] nw;
    int unsigned n = 0;
    while (busy_b && n < 300) begin @(negedge clk); n++; end
    word_b[0] = w0;
    word_b[1] = w1;
    nw = {w1, w0};
    e.cyc = cyc + LB;
    e.data = nw;
    e.pressed = nw & ~prev_b;
    e.released = prev_b & ~nw;
    prev_b = nw;
    qb.push_back(e);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    word_a[0] = '0; word_a[1] = '0;
    word_b[0] = '0; word_b[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_latch", latch_a, 0);
    check("rst_pclk", pclk_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_pressed", pr_a, 0);
    check("rst_released", rl_a, 0);
    rst = 1'b0;
    rst2 = 1'b0;

    fetch_a(8'hA3, 8'h00);
    wait_done_a();
    fetch_a(8'hC1, 8'h00);
    wait_done_a();

    // start re-pulsed mid-fetch must be dropped
    fetch_a(BA'($urandom), BA'($urandom));
    repeat (9) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();
    repeat (LA + 5) @(negedge clk);

    repeat (12) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      fetch_a(BA'($urandom), BA'($urandom));
    end
    wait_done_a();

    // reset mid-fetch
    fetch_a(BA'($urandom) | 8'h01, BA'($urandom));
    repeat (19) @(negedge clk);
    rst = 1'b1;
    qa.delete();
    act_a = 1'b0;
    prev_a = '0;
    @(negedge clk);
    check("abort_data", data_a, 0);
    check("abort_valid", valid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_latch", latch_a, 0);
    check("abort_pclk", pclk_a, 1);
    rst = 1'b0;
    @(negedge clk);
    fetch_a(BA'($urandom), BA'($urandom));
    wait_done_a();

    fetch_b(16'h8001, 16'h0000);
    wait_done_b();
    fetch_b(BB'($urandom), BB'($urandom));
    wait_done_b();

    check("auto_start_count_ge3", 32'(nstart_c >= 3), 1);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
